// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
//
// Multi-channel front end for push-buttons, touch buttons and DIP switches.
// Each channel is synchronised into the clk domain, polarity-corrected,
// debounced, and turned into a clean level plus one-cycle rise/fall pulses.
// Channels selected by REPEAT_EN_MASK also generate auto-repeat pulses while
// held, merged with rise onto press (menu / key-repeat use).
//
// Ports:
//   clk      in   game clock (33 MHz)
//   reset_n  in   asynchronous reset, active-low
//   raw_in   in   [CHANNELS] raw asynchronous pin levels
//   enable   in   global pulse enable (level is never gated)
//   level    out  [CHANNELS] debounced, polarity-corrected state (1 = pressed)
//   rise     out  [CHANNELS] one-cycle pulse on debounced press
//   fall     out  [CHANNELS] one-cycle pulse on debounced release
//   press    out  [CHANNELS] rise OR auto-repeat pulse
//
// All outputs come straight from flops. Per-channel auto-repeat state lives
// in g_ch[i].g_rep.state (IDLE / DELAY / REPEAT) for observation.
// -----------------------------------------------------------------------------
module input_conditioner #(
    parameter int                  CHANNELS        = 4,
    parameter int                  SYNC_STAGES     = 2,
    parameter int                  DEBOUNCE_CYCLES = 330000,
    parameter logic [CHANNELS-1:0] ACTIVE_LOW_MASK = '0,
    parameter logic [CHANNELS-1:0] REPEAT_EN_MASK  = '0,
    parameter int                  REPEAT_DELAY    = 16500000,
    parameter int                  REPEAT_PERIOD   = 3300000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] raw_in,
    input  logic                enable,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] press
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RP_W   = $clog2(RP_MAX + 1);

    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] DLY_LAST = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] PER_LAST = RP_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_t;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [DB_W-1:0]        db_cnt;
        logic                   lvl_q;
        logic                   rise_q;
        logic                   fall_q;
        logic                   press_q;
        logic                   c;
        logic                   differ;
        logic                   db_done;
        logic                   go_high;
        logic                   go_low;
        logic                   rep_fire;

        // Synchroniser resets to the idle pin level, so the corrected value
        // starts at 0 and reset never looks like a press.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sync_q <= {SYNC_STAGES{ACTIVE_LOW_MASK[i]}};
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in[i]};
            end
        end

        assign c       = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW_MASK[i];
        assign differ  = c ^ lvl_q;
        // Toggle on the edge where the input has disagreed with level for
        // DEBOUNCE_CYCLES consecutive samples (counter is at its last value).
        assign db_done = differ && (db_cnt == DB_LAST);
        assign go_high = db_done && !lvl_q;
        assign go_low  = db_done && lvl_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                db_cnt  <= '0;
                lvl_q   <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
                press_q <= 1'b0;
            end else begin
                if (!differ || db_done) begin
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
                if (db_done) begin
                    lvl_q <= ~lvl_q;
                end
                rise_q  <= enable && go_high;
                fall_q  <= enable && go_low;
                press_q <= (enable && go_high) || rep_fire;
            end
        end

        if (REPEAT_EN_MASK[i]) begin : g_rep
            rep_state_t      state;
            logic [RP_W-1:0] rep_cnt;
            logic            due;

            assign due = ((state == ST_DELAY)  && (rep_cnt == DLY_LAST)) ||
                         ((state == ST_REPEAT) && (rep_cnt == PER_LAST));
            // A release on the same edge as a due repeat wins: no repeat pulse.
            assign rep_fire = enable && !go_low && due;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    state   <= ST_IDLE;
                    rep_cnt <= '0;
                end else if (!enable || go_low) begin
                    state   <= ST_IDLE;
                    rep_cnt <= '0;
                end else begin
                    case (state)
                        ST_IDLE: begin
                            rep_cnt <= '0;
                            if (go_high) begin
                                state <= ST_DELAY;
                            end
                        end
                        ST_DELAY: begin
                            if (rep_cnt == DLY_LAST) begin
                                state   <= ST_REPEAT;
                                rep_cnt <= '0;
                            end else begin
                                rep_cnt <= rep_cnt + RP_W'(1);
                            end
                        end
                        ST_REPEAT: begin
                            if (rep_cnt == PER_LAST) begin
                                rep_cnt <= '0;
                            end else begin
                                rep_cnt <= rep_cnt + RP_W'(1);
                            end
                        end
                        default: begin
                            state   <= ST_IDLE;
                            rep_cnt <= '0;
                        end
                    endcase
                end
            end
        end else begin : g_norep
            assign rep_fire = 1'b0;
        end

        assign level[i] = lvl_q;
        assign rise[i]  = rise_q;
        assign fall[i]  = fall_q;
        assign press[i] = press_q;
    end

endmodule

// File: tb/tb_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_input_conditioner
//
// Bench for input_conditioner with CHANNELS=4, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, ACTIVE_LOW_MASK=0100,
// REPEAT_EN_MASK=0001. A reference model derives the outputs from input
// history (a level flips when the last DEBOUNCE_CYCLES synchronised samples all
// disagree with it; repeats fall at fixed offsets from the rise edge). Outputs
// are compared with the model at every falling clock edge; directed scenarios
// add hand-computed literal checks, followed by randomized stimulus.
// -----------------------------------------------------------------------------
module tb_input_conditioner;

    localparam int         CH = 4;
    localparam int         S  = 2;
    localparam int         D  = 4;
    localparam int         RD = 10;
    localparam int         RP = 3;
    localparam logic [3:0] AL = 4'b0100;
    localparam logic [3:0] RE = 4'b0001;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          reset_n;
    logic [CH-1:0] raw_in;
    logic          enable;
    logic [CH-1:0] level, rise, fall, press;

    always #5 clk = ~clk;

    input_conditioner #(
        .CHANNELS        (CH),
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (D),
        .ACTIVE_LOW_MASK (AL),
        .REPEAT_EN_MASK  (RE),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .raw_in  (raw_in),
        .enable  (enable),
        .level   (level),
        .rise    (rise),
        .fall    (fall),
        .press   (press)
    );

    // ---------------- reference model ----------------
    logic [3:0] m_level, m_rise, m_fall, m_press;
    logic [3:0] armed;
    int         rise_at [4];
    int         n_edge;
    logic [3:0] raw_hist [$];
    logic [3:0] c_hist   [$];

    always @(posedge clk or negedge reset_n) begin : model
        logic [3:0] c, nl, nr, nf, np, na;
        logic       tog, up, dn, rep;
        int         n, dd;
        if (!reset_n) begin
            m_level <= '0;
            m_rise  <= '0;
            m_fall  <= '0;
            m_press <= '0;
            armed   <= '0;
            n_edge  <= 0;
            raw_hist.delete();
            c_hist.delete();
        end else begin
            n = n_edge + 1;
            raw_hist.push_front(raw_in);
            if (raw_hist.size() > S) c = raw_hist[S] ^ AL;
            else                     c = 4'b0000;
            if (raw_hist.size() > S + 1) void'(raw_hist.pop_back());
            c_hist.push_front(c);
            if (c_hist.size() > D) void'(c_hist.pop_back());
            na = armed;
            for (int i = 0; i < CH; i++) begin
                tog = (c_hist.size() >= D);
                for (int j = 0; j < D; j++) begin
                    if (j < c_hist.size() && c_hist[j][i] == m_level[i]) tog = 1'b0;
                end
                up  = tog && !m_level[i];
                dn  = tog && m_level[i];
                rep = 1'b0;
                if (RE[i] && armed[i] && enable && !dn) begin
                    dd = n - rise_at[i];
                    if (dd >= RD && ((dd - RD) % RP) == 0) rep = 1'b1;
                end
                if (!enable || dn) na[i] = 1'b0;
                if (up && enable) begin
                    na[i] = 1'b1;
                    rise_at[i] <= n;
                end
                nl[i] = m_level[i] ^ tog;
                nr[i] = up && enable;
                nf[i] = dn && enable;
                np[i] = (up && enable) || rep;
            end
            m_level <= nl;
            m_rise  <= nr;
            m_fall  <= nf;
            m_press <= np;
            armed   <= na;
            n_edge  <= n;
        end
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int tick_n   = 0;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, tick_n, got, exp);
        end
    endfunction

    // Advance one cycle and compare every output with the model.
    task automatic tick();
        @(negedge clk);
        tick_n++;
        chk("level", 32'(level), 32'(m_level));
        chk("rise",  32'(rise),  32'(m_rise));
        chk("fall",  32'(fall),  32'(m_fall));
        chk("press", 32'(press), 32'(m_press));
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // ---------------- stimulus ----------------
    int   exp_offs [7] = '{10, 13, 16, 19, 22, 25, 28};
    int   got_offs [$];
    int   cnt;
    logic seen;

    initial begin
        // Reset with the active-low channel at its idle (high) level.
        reset_n = 1'b0;
        raw_in  = 4'b0100;
        enable  = 1'b1;
        ticks(3);
        reset_n = 1'b1;
        ticks(10);
        chk("reset_idle", 32'({level, rise, fall, press}), 32'd0);
        chk("model_reset_idle", 32'({m_level, m_rise, m_press}), 32'd0);

        // Clean press on ch0, auto-repeat, release with a repeat due on fall.
        raw_in[0] = 1'b1;
        ticks(5);
        chk("press_lat_early", 32'(level[0]), 32'd0);
        tick();
        chk("press_lat_level", 32'(level[0]), 32'd1);
        chk("press_lat_rise",  32'(rise[0]),  32'd1);
        chk("model_rise_at6",  32'(m_rise[0]), 32'd1);
        got_offs.delete();
        for (int t = 1; t <= 31; t++) begin
            tick();
            if (t == 1) chk("rise_one_cycle", 32'(rise[0]), 32'd0);
            if (press[0]) got_offs.push_back(t);
            if (t == 25) raw_in[0] = 1'b0;
            if (t == 31) begin
                chk("fall_at_release", 32'(fall[0]),   32'd1);
                chk("repeat_suppressed", 32'(press[0]), 32'd0);
                chk("model_fall", 32'(m_fall[0]), 32'd1);
            end
        end
        chk("repeat_count", 32'(got_offs.size()), 32'd7);
        for (int k = 0; k < 7; k++) begin
            if (k < got_offs.size()) chk("repeat_offset", 32'(got_offs[k]), 32'(exp_offs[k]));
        end
        ticks(10);
        chk("press_after_release", 32'(press[0]), 32'd0);

        // Glitch rejection on ch1: 3-cycle pulse ignored, 4-cycle accepted.
        seen = 1'b0;
        raw_in[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin tick(); seen |= level[1] | rise[1] | fall[1]; end
        raw_in[1] = 1'b0;
        for (int k = 0; k < 15; k++) begin tick(); seen |= level[1] | rise[1] | fall[1]; end
        chk("glitch3_reject", 32'(seen), 32'd0);
        cnt = 0;
        raw_in[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin tick(); cnt += int'(level[1]); end
        raw_in[1] = 1'b0;
        for (int k = 0; k < 20; k++) begin tick(); cnt += int'(level[1]); end
        chk("glitch4_width", 32'(cnt), 32'd4);

        // Active-low ch2.
        raw_in[2] = 1'b0;
        ticks(6);
        chk("al_level", 32'(level[2]), 32'd1);
        chk("al_rise",  32'(rise[2]),  32'd1);
        chk("al_press_eq_rise", 32'(press[2]), 32'(rise[2]));
        raw_in[2] = 1'b1;
        ticks(10);

        // Enable dropped mid-hold, then reset while held.
        raw_in[0] = 1'b1;
        ticks(6);
        chk("hold_rise", 32'(rise[0]), 32'd1);
        ticks(5);
        enable = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin tick(); seen |= rise[0] | fall[0] | press[0]; end
        chk("disabled_no_pulse", 32'(seen), 32'd0);
        enable = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin tick(); seen |= press[0] | rise[0]; end
        chk("reenable_no_repeat", 32'(seen), 32'd0);
        chk("reenable_level_held", 32'(level[0]), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("reset_async", 32'({level, rise, fall, press}), 32'd0);
        ticks(2);
        reset_n = 1'b1;
        ticks(5);
        chk("post_reset_early", 32'(level[0]), 32'd0);
        tick();
        chk("post_reset_rise", 32'(rise[0]), 32'd1);
        raw_in = 4'b0100;
        ticks(12);

        // Randomized stimulus; ch0 toggles slower so repeats get exercised.
        for (int k = 0; k < 3000; k++) begin
            logic [3:0] r;
            r = raw_in;
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, (c == 0) ? 39 : 11) == 0) r[c] = ~r[c];
            end
            raw_in = r;
            if ($urandom_range(0, 59) == 0) enable = ~enable;
            if ($urandom_range(0, 999) == 0) begin
                reset_n = 1'b0;
                tick();
                reset_n = 1'b1;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
